// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared constants and elaboration-time helpers for the baud tick generator:
//   - default clock / base-rate / oversample constants
//   - div_for()   : clock cycles per oversample tick for one rate
//   - min_cnt_w() : smallest prescaler width able to hold the slowest divisor
//   - ticks_t     : the registered tick bundle
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
    localparam int unsigned BASE_BAUD_DEF  = 2400;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef struct packed {
        logic os_tick;
        logic mid_tick;
        logic bit_tick;
    } ticks_t;

    // Rate sel runs at base << sel; the divisor is rounded half-up so the
    // worst-case rate error is half a clock per oversample period.
    function automatic longint unsigned div_for(
        input longint unsigned clk,
        input longint unsigned base,
        input int unsigned     sel,
        input longint unsigned os
    );
        longint unsigned r;
        r = base << sel;
        return (clk + (r * os) / 2) / (r * os);
    endfunction

    // Rate 0 is the slowest and so has the largest divisor; the counter only
    // ever holds divisor-1, so 2**w >= divisor is sufficient.
    function automatic int unsigned min_cnt_w(
        input longint unsigned clk,
        input longint unsigned base,
        input longint unsigned os
    );
        longint unsigned d;
        int unsigned     w;
        d = div_for(clk, base, 0, os);
        w = 1;
        while ((longint'(1) << w) < d) w++;
        return w;
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// ---------------------------------------------------------------------------
// baud_tick_gen_if
// Control and tick bundle of the baud tick generator.
//   enable   : 1 = run, 0 = hold phase at start
//   baud_sel : requested rate
//   sync     : single-cycle phase restart request
//   os_tick / mid_tick / bit_tick : one-cycle tick pulses
//   cur_sel  : rate currently in effect
// master = the user (UART tx/rx), slave = the generator.
// ---------------------------------------------------------------------------
interface baud_tick_gen_if #(
    parameter int unsigned SEL_W = 2
);
    logic             enable;
    logic [SEL_W-1:0] baud_sel;
    logic             sync;
    logic             os_tick;
    logic             mid_tick;
    logic             bit_tick;
    logic [SEL_W-1:0] cur_sel;

    modport master (
        output enable, baud_sel, sync,
        input  os_tick, mid_tick, bit_tick, cur_sel
    );

    modport slave (
        input  enable, baud_sel, sync,
        output os_tick, mid_tick, bit_tick, cur_sel
    );
endinterface

// File: rtl/baud_prescaler.sv
// ---------------------------------------------------------------------------
// baud_prescaler
// Reloadable down-counter.
//   clock    : system clock, rising edge
//   load     : force count to load_val (highest priority)
//   load_val : reload value (divisor - 1)
//   en       : count; on reaching zero the counter reloads load_val
//   zero     : count is zero (terminal state; the owner decides if it ticks)
// There is no reset port: the owner holds load during reset, which puts the
// counter in a known state on the same edge.
// ---------------------------------------------------------------------------
module baud_prescaler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = zero ? load_val : count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Oversample / mid-bit / bit tick generator with a power-of-two rate ladder
// above BASE_BAUD and an on-demand phase restart.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : baud_tick_gen_if.slave (enable, baud_sel, sync in;
//           os_tick, mid_tick, bit_tick, cur_sel out)
// Restart priority per edge: reset, rate change, sync, disable. A restart
// reloads the prescaler, zeroes the phase and suppresses every tick.
// ---------------------------------------------------------------------------
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BASE_BAUD  = BASE_BAUD_DEF,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic           clock,
    input  logic           reset,
    baud_tick_gen_if.slave bus
);

    localparam int unsigned NUM_RATES = 1 << SEL_W;
    localparam int unsigned PH_W      = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVERSAMPLE - 1);

    if (CNT_W < min_cnt_w(CLK_FREQ, BASE_BAUD, OVERSAMPLE)) begin : g_cnt_w_chk
        $error("baud_tick_gen: CNT_W too small for the slowest divisor");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
        $error("baud_tick_gen: OVERSAMPLE must be even and >= 4");
    end

    // Per-rate reload values (divisor - 1), fixed at elaboration.
    logic [CNT_W-1:0] div_m1 [NUM_RATES];

    for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_div
        localparam longint unsigned DIV =
            div_for(CLK_FREQ, BASE_BAUD, gi, OVERSAMPLE);
        if (DIV < 1) begin : g_div_chk
            $error("baud_tick_gen: rate too fast for CLK_FREQ");
        end
        assign div_m1[gi] = CNT_W'(DIV - 1);
    end

    ticks_t           ticks_q, ticks_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [PH_W-1:0]  phase_q, phase_d;

    logic             pre_load;
    logic [CNT_W-1:0] pre_val;
    logic             pre_en;
    logic             pre_zero;

    baud_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clock    (clock),
        .load     (pre_load),
        .load_val (pre_val),
        .en       (pre_en),
        .zero     (pre_zero)
    );

    always_comb begin
        cur_sel_d = cur_sel_q;
        phase_d   = phase_q;
        ticks_d   = '0;
        pre_load  = 1'b0;
        pre_val   = div_m1[cur_sel_q];
        pre_en    = 1'b0;

        if (!reset) begin
            cur_sel_d = '0;
            phase_d   = '0;
            pre_load  = 1'b1;
            pre_val   = div_m1[0];
        end else if (bus.baud_sel != cur_sel_q) begin
            // A rate change restarts with the new divisor, even when idle.
            cur_sel_d = bus.baud_sel;
            phase_d   = '0;
            pre_load  = 1'b1;
            pre_val   = div_m1[bus.baud_sel];
        end else if (bus.sync || !bus.enable) begin
            // Also wins over a coincident prescaler terminal count.
            phase_d  = '0;
            pre_load = 1'b1;
        end else begin
            pre_en = 1'b1;
            if (pre_zero) begin
                // mid/bit decode uses the phase before this increment.
                ticks_d.os_tick  = 1'b1;
                ticks_d.mid_tick = (phase_q == MID_PH);
                ticks_d.bit_tick = (phase_q == LAST_PH);
                phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ticks_q   <= '0;
            cur_sel_q <= '0;
            phase_q   <= '0;
        end else begin
            ticks_q   <= ticks_d;
            cur_sel_q <= cur_sel_d;
            phase_q   <= phase_d;
        end
    end

    assign bus.os_tick  = ticks_q.os_tick;
    assign bus.mid_tick = ticks_q.mid_tick;
    assign bus.bit_tick = ticks_q.bit_tick;
    assign bus.cur_sel  = cur_sel_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_gen
// Directed and randomised stimulus for baud_tick_gen at 50 MHz / 2400 base /
// 16x. The reference model only counts consecutive running edges since the
// last restart and derives every expected tick from that count with plain
// arithmetic on the published divisors.
// ---------------------------------------------------------------------------
module tb_baud_tick_gen;

    logic clock = 1'b0;
    logic reset;

    always #10 clock = ~clock;

    baud_tick_gen_if #(.SEL_W(2)) bus ();

    baud_tick_gen #(
        .CLK_FREQ   (50_000_000),
        .BASE_BAUD  (2400),
        .SEL_W      (2),
        .OVERSAMPLE (16),
        .CNT_W      (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam int unsigned OS = 16;
    int unsigned divs [4] = '{1302, 651, 326, 163};

    int unsigned     m_sel;    // rate in effect according to the model
    longint unsigned m_n;      // running edges since the last restart
    int              n_checks = 0;
    int              n_pass   = 0;
    int              dut_os   = 0;

    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        if (n_checks - n_pass >= 40) finish_bench();
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // then compare every output 1 ns later.
    task automatic cyc();
        longint unsigned k;
        logic e_os, e_mid, e_bit;
        @(posedge clock);
        if (!reset) begin
            m_sel = 0;
            m_n   = 0;
        end else if (32'(bus.baud_sel) != m_sel) begin
            m_sel = 32'(bus.baud_sel);
            m_n   = 0;
        end else if (bus.sync || !bus.enable) begin
            m_n = 0;
        end else begin
            m_n++;
        end
        #1;
        e_os  = (m_n != 0) && (m_n % divs[m_sel] == 0);
        k     = m_n / divs[m_sel];
        e_mid = e_os && ((k - 1) % OS == OS / 2 - 1);
        e_bit = e_os && ((k - 1) % OS == OS - 1);
        chk("os_tick",  32'(bus.os_tick),  32'(e_os));
        chk("mid_tick", 32'(bus.mid_tick), 32'(e_mid));
        chk("bit_tick", 32'(bus.bit_tick), 32'(e_bit));
        chk("cur_sel",  32'(bus.cur_sel),  m_sel);
        if (bus.os_tick === 1'b1) dut_os++;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Advance until the next running edge would be a prescaler terminal count.
    task automatic align_to_zero();
        int g = 0;
        while (((m_n + 1) % divs[m_sel]) != 0 && g < 2000) begin
            cyc();
            g++;
        end
    endtask

    task automatic note(input string name);
        $display("step %s: cur_sel=%0d os_ticks=%0d checks=%0d", name, bus.cur_sel, dut_os, n_checks);
        dut_os = 0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.enable   = 1'b1;
        bus.baud_sel = 2'd3;
        bus.sync     = 1'b0;
        m_sel        = 0;
        m_n          = 0;

        // Reset, then run at the fastest rate over two full bit periods.
        run(2);
        reset = 1'b1;
        run(6000);
        note("sel3_run");

        // Walk the ladder down to the slowest rate.
        bus.baud_sel = 2'd2; run(4000 + $urandom_range(0, 500));  note("sel2_run");
        bus.baud_sel = 2'd1; run(6000 + $urandom_range(0, 500));  note("sel1_run");
        bus.baud_sel = 2'd0; run(11000 + $urandom_range(0, 500)); note("sel0_run");

        // Sync at oversample phase 5.
        bus.baud_sel = 2'd3;
        cyc();
        dut_os = 0;
        begin
            int g = 0;
            while (dut_os < 5 && g < 5000) begin
                cyc();
                g++;
            end
        end
        chk("wait_os5", 32'(dut_os >= 5), 32'd1);
        bus.sync = 1'b1; cyc(); bus.sync = 1'b0;
        run(2000);
        note("sync_phase5");

        // Sync held for several cycles, random lengths.
        for (int i = 0; i < 4; i++) begin
            run($urandom_range(50, 600));
            bus.sync = 1'b1;
            run($urandom_range(1, 5));
            bus.sync = 1'b0;
        end
        run(1500);
        note("sync_held");

        // Disable mid-bit for 500 cycles.
        run(1500 + $urandom_range(0, 100));
        bus.enable = 1'b0; run(500);
        bus.enable = 1'b1; run(3000);
        note("disable");

        // Sync on the prescaler terminal edge.
        align_to_zero();
        bus.sync = 1'b1; cyc(); bus.sync = 1'b0;
        run(400);
        note("sync_at_zero");

        // Rate change together with sync, also on a terminal edge.
        align_to_zero();
        bus.baud_sel = 2'd2; bus.sync = 1'b1; cyc(); bus.sync = 1'b0;
        run(1000);
        note("sel_with_sync");

        // Reset mid-bit at sel 2, come back at sel 0.
        run($urandom_range(200, 2000));
        reset = 1'b0; bus.baud_sel = 2'd0;
        run(2);
        reset = 1'b1;
        run(3000);
        note("reset_midbit");

        // Random mix of enable, rate and sync.
        for (int i = 0; i < 20; i++) begin
            bus.enable   = ($urandom_range(0, 7) != 0);
            bus.baud_sel = 2'($urandom_range(0, 3));
            bus.sync     = ($urandom_range(0, 4) == 0);
            cyc();
            bus.sync     = 1'b0;
            run($urandom_range(1, 1000));
        end
        note("random");

        finish_bench();
    end

endmodule
